// File: rtl/tx_clk_supervisor_pkg.sv
// ============================================================================
// Module   : tx_clk_pkg
// Brief    : Shared types and defaults for the TX clock supervisor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tx_clk_pkg;

    typedef enum logic [1:0] {
        ST_RST_DCM   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_READY     = 2'd3
    } state_t;

    localparam int c_DCM_RST_CYCLES      = 4;
    localparam int c_LOCK_TIMEOUT_CYCLES = 65535;
    localparam int c_LOCK_STABLE_CYCLES  = 1024;
    localparam int c_FILTER_DEPTH        = 4;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tx_clk_supervisor_if.sv
// ============================================================================
// Module   : tx_clk_supervisor_if
// Brief    : DCM control/status and tx_engine qualification bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tx_clk_supervisor_if;
    logic       dcm_locked;
    logic       dcm_reset;
    logic       tx_ready;
    logic       tx_rst;
    logic       lock_lost;
    logic [7:0] retry_count;

    modport master (
        input  dcm_locked,
        output dcm_reset, tx_ready, tx_rst, lock_lost, retry_count
    );

    modport slave (
        output dcm_locked,
        input  dcm_reset, tx_ready, tx_rst, lock_lost, retry_count
    );
endinterface

`default_nettype wire

// File: rtl/tx_clk_supervisor_sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Brief    : Generic single-bit two-flop synchronizer, sync active-high reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_d,
    output logic      o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

`default_nettype wire

// File: rtl/tx_clk_supervisor.sv
// ============================================================================
// Module   : tx_clk_supervisor
// Brief    : TX DCM reset sequencing, lock qualification and retry; runs on
//            the free-running reference clock. Option: TXCLK_LOCK_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_clk_supervisor
    import tx_clk_pkg::*;
#(
    parameter int DCM_RST_CYCLES      = c_DCM_RST_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = c_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = c_LOCK_STABLE_CYCLES,
    parameter int CNT_W               = 16
) (
    input  wire logic           txclk,
    input  wire logic           reset,
    tx_clk_supervisor_if.master bus
);
    localparam logic [CNT_W-1:0] c_RST_LAST = CNT_W'(DCM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [7:0]       r_retry, w_retry_nxt;
    logic             r_dcm_reset, r_tx_ready, r_tx_rst, r_lock_lost;
    logic             w_dcm_reset_nxt, w_tx_ready_nxt, w_lock_lost_nxt;
    logic             w_lock_s;
    logic             w_loss;

    sync_2ff u_sync (
        .clk (txclk),
        .rst (reset),
        .i_d (bus.dcm_locked),
        .o_q (w_lock_s)
    );

`ifdef TXCLK_LOCK_FILTER_EN
    // Loss only after c_FILTER_DEPTH consecutive low samples while qualified.
    logic [1:0] r_filt, w_filt_nxt;

    always_comb begin
        w_filt_nxt = r_filt;
        if (w_lock_s || !(r_state == ST_STABLE || r_state == ST_READY))
            w_filt_nxt = 2'd0;
        else if (r_filt != 2'(c_FILTER_DEPTH - 1))
            w_filt_nxt = r_filt + 2'd1;
    end

    always_ff @(posedge txclk) begin
        if (reset) r_filt <= 2'd0;
        else       r_filt <= w_filt_nxt;
    end

    assign w_loss = !w_lock_s && (r_filt == 2'(c_FILTER_DEPTH - 1));
`else
    assign w_loss = !w_lock_s;
`endif

    always_ff @(posedge txclk) begin
        if (reset) begin
            r_state     <= ST_RST_DCM;
            r_cnt       <= '0;
            r_retry     <= 8'd0;
            r_dcm_reset <= 1'b1;
            r_tx_ready  <= 1'b0;
            r_tx_rst    <= 1'b1;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_retry     <= w_retry_nxt;
            r_dcm_reset <= w_dcm_reset_nxt;
            r_tx_ready  <= w_tx_ready_nxt;
            r_tx_rst    <= ~w_tx_ready_nxt;
            r_lock_lost <= w_lock_lost_nxt;
        end
    end

    // Every terminal compare leaves the state, so r_cnt never wraps.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_retry_nxt = r_retry;
        case (r_state)
            ST_RST_DCM: begin
                if (r_cnt == c_RST_LAST) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_TO_LAST) begin
                    w_state_nxt = ST_RST_DCM;
                    w_cnt_nxt   = '0;
                    w_retry_nxt = sat_inc8(r_retry);
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            ST_STABLE: begin
                if (w_loss) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_STB_LAST) begin
                    w_state_nxt = ST_READY;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            ST_READY: begin
                if (w_loss) begin
                    w_state_nxt = ST_RST_DCM;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_RST_DCM;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they align with it.
    always_comb begin
        w_dcm_reset_nxt = (w_state_nxt == ST_RST_DCM);
        w_tx_ready_nxt  = (w_state_nxt == ST_READY);
        w_lock_lost_nxt = (r_state == ST_READY) && w_loss;
    end

    assign bus.dcm_reset   = r_dcm_reset;
    assign bus.tx_ready    = r_tx_ready;
    assign bus.tx_rst      = r_tx_rst;
    assign bus.lock_lost   = r_lock_lost;
    assign bus.retry_count = r_retry;
endmodule

`default_nettype wire

// File: tb/tb_tx_clk_supervisor.sv
// ============================================================================
// Module   : tb_tx_clk_supervisor
// Brief    : Scoreboard bench for tx_clk_supervisor (4/100/16 timing).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tx_clk_supervisor;
    localparam int c_RST = 4;
    localparam int c_TO  = 100;
    localparam int c_STB = 16;

    typedef struct {
        bit dr;
        bit rdy;
        bit trst;
        bit ll;
        int retry;
    } exp_t;

    logic txclk;
    logic reset;
    tx_clk_supervisor_if bus ();

    tx_clk_supervisor #(
        .DCM_RST_CYCLES      (c_RST),
        .LOCK_TIMEOUT_CYCLES (c_TO),
        .LOCK_STABLE_CYCLES  (c_STB),
        .CNT_W               (16)
    ) u_dut (
        .txclk (txclk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial txclk = 1'b0;
    always #5 txclk = ~txclk;

    int   n_vec = 0;
    int   n_miscmp = 0;
    int   cyc = 0;
    int   first_hi = -1;
    int   rise_cyc = -1;
    int   ll_cnt = 0;
    int   rdy_hi_cnt = 0;
    int   run_len = 0;
    int   rise_q[$];
    int   len_q[$];
    exp_t exp_q[$];
    logic prev_dr = 1'b0;
    logic prev_rdy = 1'b0;

    // Reference model: count-down phases (0 rst_dcm, 1 wait, 2 stable, 3 ready)
    int m_s1, m_s2, m_phase, m_left, m_retry, m_low;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_miscmp++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, obs, expv);
        end
    endtask

    task automatic model_step(input logic rst, input logic lk);
        exp_t e;
        int   lock_s;
        bit   lost;
        e.ll = 1'b0;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_phase = 0; m_left = c_RST; m_retry = 0; m_low = 0;
        end else begin
            lock_s = m_s2;
            m_s2   = m_s1;
            m_s1   = int'(lk);
`ifdef TXCLK_LOCK_FILTER_EN
            lost = (lock_s == 0) && (m_low >= 3);
            if (m_phase >= 2 && lock_s == 0) m_low = m_low + 1;
            else                            m_low = 0;
`else
            lost = (lock_s == 0);
`endif
            case (m_phase)
                0: if (m_left == 1) begin m_phase = 1; m_left = c_TO; end
                   else m_left--;
                1: if (lock_s == 1) begin m_phase = 2; m_left = c_STB; end
                   else if (m_left == 1) begin
                       m_phase = 0; m_left = c_RST;
                       if (m_retry < 255) m_retry++;
                   end else m_left--;
                2: if (lost) begin m_phase = 1; m_left = c_TO; end
                   else if (m_left == 1) m_phase = 3;
                   else m_left--;
                default: if (lost) begin m_phase = 0; m_left = c_RST; e.ll = 1'b1; end
            endcase
        end
        e.dr    = (m_phase == 0);
        e.rdy   = (m_phase == 3);
        e.trst  = (m_phase != 3);
        e.retry = m_retry;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic rst, input logic lk);
        reset          = rst;
        bus.dcm_locked = lk;
        @(posedge txclk);
        cyc++;
        if (!rst && lk && first_hi < 0) first_hi = cyc;
        model_step(rst, lk);
        #1;
    endtask

    always @(negedge txclk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_vec("dcm_reset",   32'(bus.dcm_reset),   32'(e.dr));
            check_vec("tx_ready",    32'(bus.tx_ready),    32'(e.rdy));
            check_vec("tx_rst",      32'(bus.tx_rst),      32'(e.trst));
            check_vec("lock_lost",   32'(bus.lock_lost),   32'(e.ll));
            check_vec("retry_count", 32'(bus.retry_count), e.retry);
            if (bus.dcm_reset && !prev_dr) begin
                rise_q.push_back(cyc);
                run_len = 1;
            end else if (bus.dcm_reset) begin
                run_len++;
            end else if (prev_dr) begin
                len_q.push_back(run_len);
            end
            if (bus.tx_ready && !prev_rdy) rise_cyc = cyc;
            if (bus.lock_lost) ll_cnt++;
            if (bus.tx_ready)  rdy_hi_cnt++;
            prev_dr  = bus.dcm_reset;
            prev_rdy = bus.tx_ready;
        end
    end

    initial begin
        int g_cyc;
        reset = 1'b1;
        bus.dcm_locked = 1'b0;

        // Nominal lock
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0);
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1);
        check_vec("s1_latency", 32'(rise_cyc - first_hi), 32'(c_STB + 2));
        check_vec("s1_retry", 32'(bus.retry_count), 32'd0);

        // Loss in READY
        ll_cnt = 0; rise_q.delete(); len_q.delete();
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1);
        check_vec("s4_lock_lost_pulses", 32'(ll_cnt), 32'd1);
        check_vec("s4_dcm_reset_pulses", 32'(len_q.size()), 32'd1);
        if (len_q.size() > 0) check_vec("s4_dcm_reset_len", 32'(len_q[0]), 32'(c_RST));
        check_vec("s4_ready_again", 32'(bus.tx_ready), 32'd1);
        check_vec("s4_retry", 32'(bus.retry_count), 32'd0);

        // Reset in READY
        ll_cnt = 0; first_hi = -1;
        cycle(1'b1, 1'b1);
        check_vec("s6_dcm_reset", 32'(bus.dcm_reset), 32'd1);
        check_vec("s6_tx_ready",  32'(bus.tx_ready),  32'd0);
        check_vec("s6_tx_rst",    32'(bus.tx_rst),    32'd1);
        check_vec("s6_lock_lost", 32'(bus.lock_lost), 32'd0);

        // Glitch in STABLE
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1);
        rise_q.delete(); rise_cyc = -1;
        cycle(1'b0, 1'b0);
        g_cyc = cyc;
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1);
        check_vec("s3_no_dcm_reset", 32'(rise_q.size()), 32'd0);
        check_vec("s3_no_lock_lost", 32'(ll_cnt), 32'd0);
`ifdef TXCLK_LOCK_FILTER_EN
        check_vec("s3_ready_edge", 32'(rise_cyc), 32'(first_hi + c_RST + c_STB));
`else
        check_vec("s3_ready_edge", 32'(rise_cyc), 32'(g_cyc + 3 + c_STB));
`endif

        // Timeout retry
        rise_q.delete(); len_q.delete();
        cycle(1'b1, 1'b0);
        rdy_hi_cnt = 0;
        for (int i = 0; i < 350; i++) cycle(1'b0, 1'b0);
        check_vec("s2_retry", 32'(bus.retry_count), 32'd3);
        check_vec("s2_ready_low", 32'(rdy_hi_cnt), 32'd0);
        check_vec("s2_pulses", 32'(rise_q.size()), 32'd4);
        for (int i = 0; i < len_q.size(); i++)
            check_vec("s2_pulse_len", 32'(len_q[i]), 32'(c_RST));
        for (int i = 1; i < rise_q.size(); i++)
            check_vec("s2_pulse_period", 32'(rise_q[i] - rise_q[i-1]), 32'(c_RST + c_TO));

        // Saturation
        for (int i = 0; i < 260 * (c_RST + c_TO); i++) cycle(1'b0, 1'b0);
        check_vec("s5_retry_sat", 32'(bus.retry_count), 32'd255);
        for (int i = 0; i < 2 * (c_RST + c_TO); i++) cycle(1'b0, 1'b0);
        check_vec("s5_retry_hold", 32'(bus.retry_count), 32'd255);

        @(negedge txclk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule

`default_nettype wire
